cook_timer: RTL and testbench
=============================

# cook_timer

Cook-time sequencer for the microwave oven, directly upstream of the buzzer controller. Takes debounced single-cycle button pulses and the door switch, maintains an MM:SS cook time, counts it down at 1 Hz while cooking, and drives the magnetron enable. Produces the `button_pressed` beep request and the `completion_alarm` pulse train that the buzzer controller consumes.

## Interface
- `TICK_COUNT`, 100_000_000, clk cycles per cook-time second
- `ALARM_GAP`, 200_000_000, cycles between completion pulses; must exceed the buzzer alarm duration of 1 s
- `ALARM_BEEPS`, 3, number of completion pulses
- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  asynchronous, active-high
- `btn_add_min`  in  1  1-cycle pulse, +1 minute
- `btn_add_10s`  in  1  1-cycle pulse, +10 seconds
- `btn_start`  in  1  1-cycle pulse, start/resume
- `btn_cancel`  in  1  1-cycle pulse, pause/clear
- `door_open`  in  1  level, 1 = door open
- `minutes`  out  7  cook minutes, 0..99
- `seconds`  out  6  cook seconds, 0..59
- `state`  out  3  current FSM state encoding
- `magnetron_en`  out  1  high only in RUN
- `button_pressed`  out  1  1-cycle pulse per accepted button
- `completion_alarm`  out  1  1-cycle pulse per completion beep

## Operation
- States: IDLE, SET, RUN, PAUSE, DONE.
- **Priority per cycle:** cancel > door_open > start > add_min > add_10s. Only the winning event acts.
- **IDLE** (time 00:00):
  - add_min / add_10s: add time, go to SET.
  - start, cancel: ignored, no beep.
- **SET:**
  - adds apply.
  - start with door closed and time ≠ 0: go to RUN.
  - cancel: clear time, go to IDLE.
- **RUN:**
  - each tick decrements time.
  - door_open or cancel: go to PAUSE, time held.
  - adds apply while running.
  - start: ignored.
- **PAUSE:**
  - start with door closed: go to RUN.
  - cancel: clear time, go to IDLE.
  - adds apply.
- **DONE:**
  - emits ALARM_BEEPS pulses, spaced ALARM_GAP cycles apart; returns to IDLE after the last one.
  - any button or door_open aborts to IDLE immediately; no further pulses are emitted.
- **Arithmetic:**
  - +10 s: if seconds+10 ≥ 60, subtract 60 from seconds and carry 1 minute.
  - +1 min: minutes+1, seconds unchanged.
  - Saturation: any add that would exceed 99:59 yields 99:59.
  - Decrement: seconds 0 → 59 with minutes−1; otherwise seconds−1.
- **Beep rule:** `button_pressed` pulses only for accepted (state- or time-changing) presses. Rejected presses do not beep, including an add at 99:59.
- door_open alone never produces a beep.

## Timing
- Reset values: minutes 0, seconds 0, state IDLE, magnetron_en 0, button_pressed 0, completion_alarm 0, prescaler 0, beep counter 0.
- All outputs are registered. A button pulse sampled at edge N shows its effect, including `button_pressed`, after edge N.
- **Prescaler:**
  - runs only in RUN; cleared on every entry to RUN and whenever the state is not RUN.
  - the first decrement occurs TICK_COUNT cycles after entering RUN.
- **Completion:** when a tick hits time 00:01, the same edge sets time 00:00, state DONE, and `completion_alarm` = 1. Subsequent pulses follow every ALARM_GAP cycles.
- **door_open in RUN:** magnetron_en drops the edge after door_open is sampled.
- **Reset mid-run:** all registers clear asynchronously and magnetron_en drops immediately.

## Structure
- Package `oven_pkg`:
  - state enum
  - MAX_MIN = 99, MAX_SEC = 59, ADD_SEC = 10
  - shared between this block and the display driver.
- One sub-module `tick_prescaler`:
  - inputs: enable, clear
  - output: 1-cycle tick every TICK_COUNT cycles
  - instantiated twice: cook tick and alarm gap, the latter with ALARM_GAP.

## Test plan
Parameters for all scenarios: TICK_COUNT=10, ALARM_GAP=20, ALARM_BEEPS=3.
1. add_10s ×2, start → state RUN, magnetron_en 1, 00:20. After 200 cycles: 00:00, DONE. Three `completion_alarm` pulses 20 cycles apart, then IDLE.
2. add_min ×99, then add_10s ×7 → saturates at 99:59. The last add produces no `button_pressed`.
3. 01:00 running, door_open at tick 3 → PAUSE at 00:57, magnetron_en 0. Close door, start → resumes; next decrement exactly 10 cycles later.
4. btn_cancel and btn_start in the same cycle during RUN → PAUSE; one `button_pressed` pulse.
5. DONE with first alarm pulse emitted; btn_add_min → IDLE next cycle, no further `completion_alarm`.
6. Reset asserted mid-RUN at 00:45 → all outputs 0 asynchronously. start in IDLE afterwards is ignored, with no beep.

Source files
------------

// File: rtl/oven_pkg.sv
// Oven-wide types and time limits, shared by the cook timer and the display driver.
package oven_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Winning button/door event of a cycle after priority resolution
    typedef enum logic [2:0] {
        EV_NONE,
        EV_CANCEL,
        EV_DOOR,
        EV_START,
        EV_ADD_MIN,
        EV_ADD_10S
    } event_e;

    localparam logic [6:0] MAX_MIN = 7'd99;
    localparam logic [5:0] MAX_SEC = 6'd59;
    localparam logic [5:0] ADD_SEC = 6'd10;
    // Seconds value at which +10 s wraps into the next minute
    localparam logic [5:0] CARRY_AT = 6'd60 - ADD_SEC;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every COUNT enabled cycles, restartable by clear.
module tick_prescaler #(
    parameter int COUNT = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_tick
);

    localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [W-1:0] r_count;

    assign o_tick = i_enable && (r_count == W'(COUNT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook-time sequencer: MM:SS entry, 1 Hz countdown, magnetron enable,
// button beep requests and the completion alarm pulse train.
module cook_timer
    import oven_pkg::*;
#(
    parameter int TICK_COUNT  = 100_000_000,
    parameter int ALARM_GAP   = 200_000_000,
    parameter int ALARM_BEEPS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_add_min,
    input  logic       i_btn_add_10s,
    input  logic       i_btn_start,
    input  logic       i_btn_cancel,
    input  logic       i_door_open,
    output logic [6:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic [2:0] o_state,
    output logic       o_magnetron_en,
    output logic       o_button_pressed,
    output logic       o_completion_alarm
);

    localparam int              BEEP_W    = $clog2(ALARM_BEEPS + 1);
    localparam logic [BEEP_W-1:0] LAST_BEEP = BEEP_W'(ALARM_BEEPS - 1);

    state_e            r_state, w_state_next;
    event_e            w_event;
    logic [6:0]        r_min, w_min_next, w_base_min, w_add_min;
    logic [5:0]        r_sec, w_sec_next, w_base_sec, w_add_sec;
    logic [BEEP_W-1:0] r_beep_cnt, w_beep_next;
    logic              r_mag, r_btn, r_alarm;
    logic              w_btn, w_alarm, w_add_ok, w_cook_tick, w_gap_tick;

    tick_prescaler #(.COUNT(TICK_COUNT)) u_cook_tick (
        .clk      (clk),
        .reset    (reset),
        .i_enable (r_state == ST_RUN),
        .i_clear  (r_state != ST_RUN),
        .o_tick   (w_cook_tick)
    );

    tick_prescaler #(.COUNT(ALARM_GAP)) u_alarm_gap (
        .clk      (clk),
        .reset    (reset),
        .i_enable (r_state == ST_DONE),
        .i_clear  (r_state != ST_DONE),
        .o_tick   (w_gap_tick)
    );

    always_comb begin
        w_event = EV_NONE;
        if (i_btn_cancel)       w_event = EV_CANCEL;
        else if (i_door_open)   w_event = EV_DOOR;
        else if (i_btn_start)   w_event = EV_START;
        else if (i_btn_add_min) w_event = EV_ADD_MIN;
        else if (i_btn_add_10s) w_event = EV_ADD_10S;
    end

    // Adds while running apply on top of this cycle's decrement, so both take effect
    always_comb begin
        w_base_min = r_min;
        w_base_sec = r_sec;
        if (r_state == ST_RUN && w_cook_tick) begin
            if (r_sec == '0) begin
                w_base_min = r_min - 7'd1;
                w_base_sec = MAX_SEC;
            end else begin
                w_base_sec = r_sec - 6'd1;
            end
        end
        w_add_min = w_base_min;
        w_add_sec = w_base_sec;
        if (w_event == EV_ADD_MIN) begin
            if (w_base_min == MAX_MIN) w_add_sec = MAX_SEC;
            else                       w_add_min = w_base_min + 7'd1;
        end else if (w_event == EV_ADD_10S) begin
            if (w_base_sec < CARRY_AT) begin
                w_add_sec = w_base_sec + ADD_SEC;
            end else if (w_base_min == MAX_MIN) begin
                w_add_sec = MAX_SEC;
            end else begin
                w_add_min = w_base_min + 7'd1;
                w_add_sec = w_base_sec - CARRY_AT;
            end
        end
        w_add_ok = (w_add_min != w_base_min) || (w_add_sec != w_base_sec);
    end

    always_comb begin
        w_state_next = r_state;
        w_min_next   = r_min;
        w_sec_next   = r_sec;
        w_beep_next  = '0;
        w_btn        = 1'b0;
        w_alarm      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event == EV_ADD_MIN || w_event == EV_ADD_10S) begin
                    w_state_next = ST_SET;
                    w_min_next   = w_add_min;
                    w_sec_next   = w_add_sec;
                    w_btn        = 1'b1;
                end
            end
            ST_SET, ST_PAUSE: begin
                case (w_event)
                    EV_CANCEL: begin
                        w_state_next = ST_IDLE;
                        w_min_next   = '0;
                        w_sec_next   = '0;
                        w_btn        = 1'b1;
                    end
                    EV_START: begin
                        if (r_min != '0 || r_sec != '0) begin
                            w_state_next = ST_RUN;
                            w_btn        = 1'b1;
                        end
                    end
                    EV_ADD_MIN, EV_ADD_10S: begin
                        if (w_add_ok) begin
                            w_min_next = w_add_min;
                            w_sec_next = w_add_sec;
                            w_btn      = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_RUN: begin
                case (w_event)
                    EV_CANCEL: begin
                        w_state_next = ST_PAUSE;
                        w_btn        = 1'b1;
                    end
                    EV_DOOR: w_state_next = ST_PAUSE;
                    default: begin
                        w_min_next = w_base_min;
                        w_sec_next = w_base_sec;
                        if (w_add_ok) begin
                            w_min_next = w_add_min;
                            w_sec_next = w_add_sec;
                            w_btn      = 1'b1;
                        end
                        if (w_min_next == '0 && w_sec_next == '0) begin
                            w_state_next = (ALARM_BEEPS > 1) ? ST_DONE : ST_IDLE;
                            w_alarm      = 1'b1;
                            w_beep_next  = BEEP_W'(1);
                        end
                    end
                endcase
            end
            ST_DONE: begin
                case (w_event)
                    EV_NONE: begin
                        w_beep_next = r_beep_cnt;
                        if (w_gap_tick) begin
                            w_alarm = 1'b1;
                            if (r_beep_cnt == LAST_BEEP) w_state_next = ST_IDLE;
                            else                         w_beep_next  = r_beep_cnt + 1'b1;
                        end
                    end
                    EV_DOOR: w_state_next = ST_IDLE;
                    default: begin
                        w_state_next = ST_IDLE;
                        w_btn        = 1'b1;
                    end
                endcase
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_min      <= '0;
            r_sec      <= '0;
            r_beep_cnt <= '0;
            r_mag      <= 1'b0;
            r_btn      <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_min      <= w_min_next;
            r_sec      <= w_sec_next;
            r_beep_cnt <= w_beep_next;
            r_mag      <= (w_state_next == ST_RUN);
            r_btn      <= w_btn;
            r_alarm    <= w_alarm;
        end
    end

    assign o_minutes          = r_min;
    assign o_seconds          = r_sec;
    assign o_state            = r_state;
    assign o_magnetron_en     = r_mag;
    assign o_button_pressed   = r_btn;
    assign o_completion_alarm = r_alarm;

endmodule

// File: tb/tb_cook_timer.sv
// Cook timer bench: directed scenarios plus random button/door traffic against a
// total-seconds reference model, with beep and alarm pulses checked by a scoreboard.
module tb_cook_timer;
    import oven_pkg::*;

    localparam int TICK  = 10;
    localparam int GAP   = 20;
    localparam int BEEPS = 3;
    localparam int MAX_T = 99 * 60 + 59;

    logic       clk = 1'b0;
    logic       reset;
    logic       add_min, add_10s, start, cancel, door;
    logic [6:0] o_minutes;
    logic [5:0] o_seconds;
    logic [2:0] o_state;
    logic       o_magnetron_en, o_button_pressed, o_completion_alarm;

    cook_timer #(.TICK_COUNT(TICK), .ALARM_GAP(GAP), .ALARM_BEEPS(BEEPS)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_btn_add_min      (add_min),
        .i_btn_add_10s      (add_10s),
        .i_btn_start        (start),
        .i_btn_cancel       (cancel),
        .i_door_open        (door),
        .o_minutes          (o_minutes),
        .o_seconds          (o_seconds),
        .o_state            (o_state),
        .o_magnetron_en     (o_magnetron_en),
        .o_button_pressed   (o_button_pressed),
        .o_completion_alarm (o_completion_alarm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int beep_q[$];
    int alarm_q[$];

    // Reference model: cook time held as total seconds, timing as edge numbers
    state_e m_state;
    int     m_t, m_run_start, m_done_start;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void model_reset();
        m_state = ST_IDLE;
        m_t = 0;
        m_run_start = 0;
        m_done_start = 0;
    endfunction

    function automatic int sat_add(input int t, input int delta);
        return (t + delta > MAX_T) ? MAX_T : t + delta;
    endfunction

    // Advance the model across the next rising edge with the given inputs
    function automatic void model_step(input logic am, input logic a10, input logic st,
                                       input logic ca, input logic dr);
        int  e = edge_cnt + 1;
        int  delta = 0;
        bit  beep = 0, alarm = 0;
        bit  is_add;
        int  k;
        if (ca)       begin end
        else if (dr)  begin end
        else if (st)  begin end
        else if (am)  delta = 60;
        else if (a10) delta = 10;
        is_add = (delta != 0);
        case (m_state)
            ST_IDLE: if (is_add) begin m_t = sat_add(m_t, delta); m_state = ST_SET; beep = 1; end
            ST_SET, ST_PAUSE: begin
                if (ca) begin m_t = 0; m_state = ST_IDLE; beep = 1; end
                else if (dr) begin end
                else if (st) begin
                    if (m_t != 0) begin m_state = ST_RUN; m_run_start = e; beep = 1; end
                end else if (is_add && sat_add(m_t, delta) != m_t) begin
                    m_t = sat_add(m_t, delta); beep = 1;
                end
            end
            ST_RUN: begin
                if (ca) begin m_state = ST_PAUSE; beep = 1; end
                else if (dr) m_state = ST_PAUSE;
                else begin
                    if ((e - m_run_start) % TICK == 0) m_t = m_t - 1;
                    if (is_add && sat_add(m_t, delta) != m_t) begin
                        m_t = sat_add(m_t, delta); beep = 1;
                    end
                    if (m_t == 0) begin m_state = ST_DONE; m_done_start = e; alarm = 1; end
                end
            end
            ST_DONE: begin
                if (ca || dr || st || is_add) begin m_state = ST_IDLE; beep = !dr || ca; end
                else begin
                    k = e - m_done_start;
                    if (k % GAP == 0) begin
                        alarm = 1;
                        if (k / GAP == BEEPS - 1) m_state = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase
        if (beep)  beep_q.push_back(e);
        if (alarm) alarm_q.push_back(e);
    endfunction

    task automatic check_state(input string tag);
        int em = m_t / 60;
        int es = m_t % 60;
        logic emag = (m_state == ST_RUN);
        total++;
        if (o_state !== m_state || o_minutes !== 7'(em) || o_seconds !== 6'(es) || o_magnetron_en !== emag) begin
            bad++;
            $display("FAIL %s edge=%0d: got state=%0d time=%0d:%0d mag=%0b, required state=%0d time=%0d:%0d mag=%0b",
                     tag, edge_cnt, o_state, o_minutes, o_seconds, o_magnetron_en, m_state, em, es, emag);
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        if (o_state !== 3'd0 || o_minutes !== 7'd0 || o_seconds !== 6'd0 || o_magnetron_en !== 1'b0 ||
            o_button_pressed !== 1'b0 || o_completion_alarm !== 1'b0) begin
            bad++;
            $display("FAIL %s: got state=%0d time=%0d:%0d mag=%0b beep=%0b alarm=%0b, required all 0",
                     tag, o_state, o_minutes, o_seconds, o_magnetron_en, o_button_pressed, o_completion_alarm);
        end
    endtask

    // One clock: drive at a falling edge, step the model, check at the next falling edge
    task automatic cycle(input logic am, input logic a10, input logic st, input logic ca, input logic dr,
                         input string tag = "state");
        add_min = am; add_10s = a10; start = st; cancel = ca; door = dr;
        model_step(am, a10, st, ca, dr);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    // Scoreboard monitor for the pulse outputs
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            while (beep_q.size() > 0 && beep_q[0] < edge_cnt) begin
                total++; bad++;
                $display("FAIL beep_missing: got no button_pressed, required one at edge %0d", beep_q.pop_front());
            end
            while (alarm_q.size() > 0 && alarm_q[0] < edge_cnt) begin
                total++; bad++;
                $display("FAIL alarm_missing: got no completion_alarm, required one at edge %0d", alarm_q.pop_front());
            end
            if (o_button_pressed === 1'b1) begin
                total++;
                if (beep_q.size() > 0 && beep_q[0] == edge_cnt) begin
                    void'(beep_q.pop_front());
                    $display("beep  edge=%0d time=%0d:%0d state=%0d", edge_cnt, o_minutes, o_seconds, o_state);
                end else begin
                    bad++;
                    $display("FAIL beep_unexpected: got button_pressed at edge %0d, required none", edge_cnt);
                end
            end
            if (o_completion_alarm === 1'b1) begin
                total++;
                if (alarm_q.size() > 0 && alarm_q[0] == edge_cnt) begin
                    void'(alarm_q.pop_front());
                    $display("alarm edge=%0d state=%0d", edge_cnt, o_state);
                end else begin
                    bad++;
                    $display("FAIL alarm_unexpected: got completion_alarm at edge %0d, required none", edge_cnt);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic dr;
        reset = 1'b1;
        add_min = 0; add_10s = 0; start = 0; cancel = 0; door = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset_values");
        reset = 1'b0;

        // Two +10 s, start, run to completion and the full alarm train
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, "start_20s");
        idle(200 + 2 * GAP + 10);

        // Saturation at 99:59; the final +10 s must not beep
        for (int i = 0; i < 99; i++) cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 0, "saturate");
        cycle(1, 0, 0, 0, 0, "add_at_max");
        cycle(0, 0, 0, 1, 0);

        // Door opened after the third tick of a one-minute run, then resume
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(3 * TICK);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, "door_pause");
        idle(3);
        cycle(0, 0, 1, 0, 0, "resume");
        idle(25);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // Cancel and start in the same cycle while running
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(15);
        cycle(0, 0, 1, 1, 0, "cancel_start");
        cycle(0, 0, 0, 1, 0);

        // Abort the alarm train after its first pulse
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(10 * TICK + 3);
        cycle(1, 0, 0, 0, 0, "done_abort");
        idle(3 * GAP);

        // Asynchronous reset in the middle of a run at 00:45
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(5 * TICK);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        beep_q.delete();
        alarm_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, 1, 0, 0, "start_in_idle");
        idle(5);

        // Random traffic: busy segments exercise priority, quiet ones let runs finish
        dr = 0;
        for (int seg = 0; seg < 24; seg++) begin
            for (int i = 0; i < 100; i++) begin
                if (seg % 2 == 0) begin
                    if ($urandom_range(0, 39) == 0) dr = !dr;
                    cycle($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, dr, "random");
                end else begin
                    if ($urandom_range(0, 59) == 0) dr = !dr;
                    cycle(0, 0, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0, dr, "random");
                end
            end
        end
        idle(3 * GAP);
        @(negedge clk);

        total++;
        if (beep_q.size() != 0 || alarm_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_pulses: got %0d beeps and %0d alarms outstanding, required 0",
                     beep_q.size(), alarm_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
